// File: rtl/uart_tx.sv
// uart_tx: UART transmitter sharing the receiver's oversampling clock.
// Serialises a byte LSB-first as start bit, data bits, optional parity bit
// and stop bit, holding each serial bit for PRESCALE clock cycles.
// Optional build macro: UART_TX_TWO_STOP_EN (two stop bits instead of one).
module uart_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE   = 8
) (
    input  logic                  clk_based_on_prescale,
    input  logic                  asy_reset,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic                  tx_out,
    output logic                  busy
);

    localparam int CW = $clog2(PRESCALE);
    localparam int BW = $clog2(DATA_WIDTH);

    localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);
`ifdef UART_TX_TWO_STOP_EN
    localparam logic [BW-1:0] STOP_LAST = BW'(1);
`else
    localparam logic [BW-1:0] STOP_LAST = BW'(0);
`endif

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state, state_n;
    logic [CW-1:0]         prescale_cnt, prescale_cnt_n;
    logic [BW-1:0]         bit_cnt, bit_cnt_n;
    logic [DATA_WIDTH-1:0] data_reg, data_reg_n;
    logic                  par_en_reg, par_en_reg_n;
    logic                  par_bit, par_bit_n;
    logic                  tx_n, busy_n;

    logic                  cnt_end;
    logic                  last_stop;
    logic                  accept;
    logic [BW-1:0]         next_bit;

    // The bit counter is reused during STOP to count stop bits, so the end
    // of the frame is the last prescale cycle of the last stop bit. A
    // request seen at that exact edge starts the next frame with no gap.
    assign cnt_end   = (prescale_cnt == CNT_LAST);
    assign last_stop = (state == STOP) && cnt_end && (bit_cnt == STOP_LAST);
    assign accept    = data_valid && ((state == IDLE) || last_stop);
    assign next_bit  = bit_cnt + 1'b1;

    // Next-state and next-output logic; every register holds unless changed.
    always_comb begin
        state_n        = state;
        prescale_cnt_n = prescale_cnt;
        bit_cnt_n      = bit_cnt;
        data_reg_n     = data_reg;
        par_en_reg_n   = par_en_reg;
        par_bit_n      = par_bit;
        tx_n           = tx_out;
        busy_n         = busy;

        if (!cnt_end) begin
            prescale_cnt_n = prescale_cnt + 1'b1;
        end else begin
            prescale_cnt_n = '0;
        end

        case (state)
            IDLE: begin
                prescale_cnt_n = '0;
                tx_n           = 1'b1;
                busy_n         = 1'b0;
            end
            START: begin
                if (cnt_end) begin
                    state_n   = DATA;
                    bit_cnt_n = '0;
                    tx_n      = data_reg[0];
                end
            end
            DATA: begin
                if (cnt_end) begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt_n = '0;
                        if (par_en_reg) begin
                            state_n = PARITY;
                            tx_n    = par_bit;
                        end else begin
                            state_n = STOP;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        bit_cnt_n = next_bit;
                        tx_n      = data_reg[next_bit];
                    end
                end
            end
            PARITY: begin
                if (cnt_end) begin
                    state_n   = STOP;
                    bit_cnt_n = '0;
                    tx_n      = 1'b1;
                end
            end
            STOP: begin
                if (cnt_end) begin
                    if (bit_cnt == STOP_LAST) begin
                        state_n = IDLE;
                        tx_n    = 1'b1;
                        busy_n  = 1'b0;
                    end else begin
                        bit_cnt_n = next_bit;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
                busy_n  = 1'b0;
            end
        endcase

        // Acceptance latches the request and parity so later input changes
        // cannot disturb the frame in flight.
        if (accept) begin
            state_n        = START;
            prescale_cnt_n = '0;
            bit_cnt_n      = '0;
            data_reg_n     = p_data;
            par_en_reg_n   = par_en;
            par_bit_n      = (^p_data) ^ par_typ;
            tx_n           = 1'b0;
            busy_n         = 1'b1;
        end
    end

    // State and output registers; reset aborts any frame without a clock.
    always_ff @(posedge clk_based_on_prescale or negedge asy_reset) begin
        if (!asy_reset) begin
            state        <= IDLE;
            prescale_cnt <= '0;
            bit_cnt      <= '0;
            data_reg     <= '0;
            par_en_reg   <= 1'b0;
            par_bit      <= 1'b0;
            tx_out       <= 1'b1;
            busy         <= 1'b0;
        end else begin
            state        <= state_n;
            prescale_cnt <= prescale_cnt_n;
            bit_cnt      <= bit_cnt_n;
            data_reg     <= data_reg_n;
            par_en_reg   <= par_en_reg_n;
            par_bit      <= par_bit_n;
            tx_out       <= tx_n;
            busy         <= busy_n;
        end
    end

endmodule
